// File: rtl/cla_pkg.sv
// Shared definitions for the CLA adder family: sequencer states, nibble width
// and the nibble-count helper used to size the serial adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_logic_4bit.sv
// 4-bit carry-lookahead slice: turns per-bit generate/propagate terms and a
// carry-in into the carry entering each bit plus the slice carry-out.
module cla_logic_4bit (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       cin_i,
  output logic [3:0] carry_o,
  output logic       cout_o
);

  // carry_o[k] is the carry into bit k; carry_o[0] is the slice carry-in.
  assign carry_o[0] = cin_i;
  assign carry_o[1] = g_i[0] | (p_i[0] & cin_i);
  assign carry_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
  assign carry_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                    | (p_i[2] & p_i[1] & p_i[0] & cin_i);
  assign cout_o     = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                    | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                    | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & cin_i);

endmodule

// File: rtl/cla_serial_adder_seq.sv
// Nibble-serial adder sharing one cla_logic_4bit slice, LSB nibble first.
// Optional signed-overflow flag and ovf_o port under `SERIAL_ADD_OVF_EN.
module cla_serial_adder_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o,
  output state_t           state_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_serial_adder_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic             last_nib;
  logic [3:0]       a_nib, b_nib, p_nib, g_nib, slice_carry, sum_nib;
  logic             slice_cout;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready_o/valid_o come from state alone so neither depends
  // combinationally on the partner's valid_i/ready_i.
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state == RUN);
  assign state_o = state;
  assign sum_o   = sum_q;
  assign cout_o  = carry_q;

  assign last_nib = (cnt == CNT_W'(NIB - 1));
  assign a_nib    = a_q[{cnt, 2'b00} +: NIBBLE_W];
  assign b_nib    = b_q[{cnt, 2'b00} +: NIBBLE_W];
  assign p_nib    = a_nib ^ b_nib;
  assign g_nib    = a_nib & b_nib;
  assign sum_nib  = p_nib ^ {slice_carry[3:1], carry_q};

  cla_logic_4bit u_slice (
    .p_i     (p_nib),
    .g_i     (g_nib),
    .cin_i   (carry_q),
    .carry_o (slice_carry),
    .cout_o  (slice_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i)  state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (ready_i)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            cnt     <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[{cnt, 2'b00} +: NIBBLE_W] <= sum_nib;
          carry_q <= slice_cout;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  assign ovf_o = ovf_q;

  // Signed overflow: carry into the MSB differs from the carry out of it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && valid_i) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last_nib) begin
      ovf_q <= slice_carry[3] ^ slice_cout;
    end
  end
`endif

endmodule

// File: tb/tb_cla_serial_adder_seq.sv
// Self-checking bench for cla_serial_adder_seq: directed test-plan vectors,
// mid-run reset, backpressure and a random back-to-back stream.
module tb_cla_serial_adder_seq;
  import cla_pkg::*;

  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         busy_o;
  state_t       state_o;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf_o;
`endif

  cla_serial_adder_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .busy_o  (busy_o),
    .state_o (state_o)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int prev_acc = -1;
  bit track_int = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Issue one operation, follow it to completion, hold ready_i low for
  // 'stall' cycles in DONE, then complete the output handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stall, input bit scramble);
    int t;
    int lat;
    logic [W+1:0] e;
    logic [W-1:0] held_sum;
    logic         held_cout;
    t = 0;
    while (!ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_accept", ready_o, 1);
    a_i = a; b_i = b; cin_i = c; valid_i = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (track_int && prev_acc >= 0) check("issue_interval_ok", (cyc - prev_acc) >= NIB + 1, 1);
    prev_acc = cyc;
    lat = 0;
    @(negedge clk);
    check("busy_in_run", busy_o, 1);
    while (!valid_o && lat < 50) begin
      check("ready_low_run", ready_o, 0);
      if (scramble) begin
        a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom); valid_i = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    check("latency", lat, NIB);
    e = exp_q.pop_front();
    check("sum", sum_o, e[W-1:0]);
    check("cout", cout_o, e[W]);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", ovf_o, e[W+1]);
`endif
    held_sum  = sum_o;
    held_cout = cout_o;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", valid_o, 1);
      check("bp_ready", ready_o, 0);
      check("bp_sum", sum_o, held_sum);
      check("bp_cout", cout_o, held_cout);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    @(negedge clk);
    check("ready_after_hs", ready_o, 1);
    check("valid_after_hs", valid_o, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // reset
    repeat (3) @(negedge clk);
    check("rst_state", state_o, IDLE);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_cout", cout_o, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", ovf_o, 0);
`endif
    rst_i = 1'b0;
    @(negedge clk);

    // directed vectors
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    check("k1_sum", sum_o, 32'h00000000);
    check("k1_cout", cout_o, 1);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 1'b1);
    check("k2_sum", sum_o, 32'hACF13568);
    check("k2_cout", cout_o, 0);
    run_op(32'h0, 32'h0, 1'b1, 0, 1'b0);
    check("k3_sum", sum_o, 32'h00000001);
    check("k3_cout", cout_o, 0);
`ifdef SERIAL_ADD_OVF_EN
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    check("k4_sum", sum_o, 32'h80000000);
    check("k4_ovf", ovf_o, 1);
    check("k4_cout", cout_o, 0);
`endif

    // backpressure
    run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 5, 1'b0);

    // reset during nibble 3
    a_i = 32'hAAAA5555; b_i = 32'h5555AAAA; cin_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_state", state_o, IDLE);
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_sum", sum_o, 0);
    run_op(32'd5, 32'd7, 1'b0, 0, 1'b0);
    check("after_rst_sum", sum_o, 32'h0000000C);

    // random back-to-back stream
    track_int = 1'b1;
    prev_acc  = -1;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = 32'h7FFFFFFF;
      run_op(ra, rb, 1'($urandom), (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
